// File: rtl/centipede_audio_out.sv
// centipede_audio_out
//   Output stage behind the POKEY mix. Box-car decimates the 8-bit unsigned
//   mix by 2**DECIM_LOG2, centres it, volume-scales it to 16-bit signed PCM,
//   presents it on a valid/ready handshake and drives a first-order
//   sigma-delta 1-bit DAC from the held PCM word.
//
//   Optional feature: define CENTIPEDE_AUDIO_DCBLOCK_EN to insert a DC-blocking
//   high-pass (y = x - x_prev + y_prev - y_prev/256, saturated) at PCM rate.
//
// Ports
//   clk_cpu_4x   in   6 MHz clock, all state on rising edge
//   reset_cpu_n  in   asynchronous active-low reset
//   sample_en    in   strobe marking a new audio_in sample
//   audio_in     in   [7:0] unsigned mix, 8'h80 = silence
//   volume       in   [3:0] gain = volume + 1
//   mute         in   forces a zero word when high on a boundary strobe
//   pcm_data     out  [15:0] signed PCM
//   pcm_valid    out  pcm_data holds an unconsumed word
//   pcm_ready    in   consumer accept (with pcm_valid)
//   pcm_overrun  out  sticky: a word was overwritten before acceptance
//   dac_out      out  sigma-delta bitstream
module centipede_audio_out #(
    parameter int unsigned DECIM_LOG2 = 5
) (
    input  logic        clk_cpu_4x,
    input  logic        reset_cpu_n,
    input  logic        sample_en,
    input  logic [7:0]  audio_in,
    input  logic [3:0]  volume,
    input  logic        mute,
    output logic [15:0] pcm_data,
    output logic        pcm_valid,
    input  logic        pcm_ready,
    output logic        pcm_overrun,
    output logic        dac_out
);

    localparam int unsigned SW = 8 + DECIM_LOG2;

    logic [DECIM_LOG2-1:0] cnt;
    logic [SW-1:0]         sum;
    logic [SW-1:0]         total;
    logic                  boundary;
    logic [7:0]            avg;
    logic signed [12:0]    c13;
    logic signed [12:0]    g13;
    logic signed [12:0]    s13;
    logic [15:0]           pcm;
    logic [15:0]           x;
    logic [15:0]           y;
    logic [15:0]           sd_acc;
    logic [15:0]           u;

    assign boundary = sample_en && (cnt == '1);
    assign total    = sum + SW'(audio_in);
    assign avg      = total[SW-1:DECIM_LOG2];

    // Centre to -128..127, then scale by 1..16; product fits 13 bits signed.
    assign c13 = 13'(signed'({1'b0, avg})) - 13'sd128;
    assign g13 = signed'(13'({1'b0, volume}) + 13'd1);
    assign s13 = c13 * g13;

    // s13 lies in -2048..2032, so bit 12 is redundant and the shift is exact.
    assign pcm = {s13[11:0], 4'b0000};
    assign x   = mute ? '0 : pcm;

`ifdef CENTIPEDE_AUDIO_DCBLOCK_EN
    logic signed [15:0] x_prev;
    logic signed [15:0] y_prev;
    logic signed [17:0] y18;

    always_comb begin
        y18 = 18'(signed'(x)) - 18'(x_prev) + 18'(y_prev) - 18'(y_prev >>> 8);
        y   = y18[15:0];
        if (y18[17:15] != 3'b000 && y18[17:15] != 3'b111)
            y = y18[17] ? 16'h8000 : 16'h7FFF;
    end

    always_ff @(posedge clk_cpu_4x or negedge reset_cpu_n) begin
        if (!reset_cpu_n) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (boundary) begin
            x_prev <= signed'(x);
            y_prev <= signed'(y);
        end
    end
`else
    assign y = x;
`endif

    // Decimator
    always_ff @(posedge clk_cpu_4x or negedge reset_cpu_n) begin
        if (!reset_cpu_n) begin
            cnt <= '0;
            sum <= '0;
        end else if (sample_en) begin
            if (boundary) begin
                cnt <= '0;
                sum <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                sum <= total;
            end
        end
    end

    // Output register and handshake. A boundary always loads; an accept in the
    // same cycle consumes the old word, so only an unaccepted word overruns.
    always_ff @(posedge clk_cpu_4x or negedge reset_cpu_n) begin
        if (!reset_cpu_n) begin
            pcm_data    <= '0;
            pcm_valid   <= 1'b0;
            pcm_overrun <= 1'b0;
        end else if (boundary) begin
            pcm_data  <= y;
            pcm_valid <= 1'b1;
            if (pcm_valid && !pcm_ready)
                pcm_overrun <= 1'b1;
        end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
        end
    end

    // Sigma-delta: carry out of the offset-binary accumulator is the DAC bit.
    assign u = pcm_data ^ 16'h8000;

    always_ff @(posedge clk_cpu_4x or negedge reset_cpu_n) begin
        if (!reset_cpu_n) begin
            sd_acc  <= '0;
            dac_out <= 1'b0;
        end else begin
            {dac_out, sd_acc} <= {1'b0, sd_acc} + {1'b0, u};
        end
    end

endmodule

// File: tb/tb_centipede_audio_out.sv
module tb_centipede_audio_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [7:0]  audio_in;
    logic [3:0]  volume;
    logic        mute;
    logic [15:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        pcm_overrun;
    logic        dac_out;

    int total = 0;
    int bad   = 0;
    int gap   = 3;

    centipede_audio_out #(.DECIM_LOG2(5)) dut (
        .clk_cpu_4x  (clk),
        .reset_cpu_n (rst_n),
        .sample_en   (sample_en),
        .audio_in    (audio_in),
        .volume      (volume),
        .mute        (mute),
        .pcm_data    (pcm_data),
        .pcm_valid   (pcm_valid),
        .pcm_ready   (pcm_ready),
        .pcm_overrun (pcm_overrun),
        .dac_out     (dac_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [3:0]  vol;
        logic        m;
        logic [15:0] exp_pcm;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One strobe: inputs change 1 time unit after an edge, the strobe is
    // captured at the next edge, and the task returns 1 unit after it.
    task automatic strobe(input logic [7:0] a, input logic m, input logic rdy);
        repeat (gap) @(posedge clk);
        #1;
        sample_en = 1'b1;
        audio_in  = a;
        mute      = m;
        pcm_ready = rdy;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        mute      = 1'b0;
        pcm_ready = 1'b0;
        audio_in  = 8'h5A;
    endtask

    task automatic strobes(input int n, input logic [7:0] a, input logic m);
        for (int i = 0; i < n; i++) strobe(a, m, 1'b0);
    endtask

    task automatic accept;
        #1;
        pcm_ready = 1'b1;
        @(posedge clk);
        #1;
        pcm_ready = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] held;
        int ones;
        int toggles;
        logic last;

        rst_n = 1'b1; sample_en = 1'b0; audio_in = 8'h00;
        volume = 4'd0; mute = 1'b0; pcm_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_pcm", 32'(pcm_data), 32'h0);
        chk("reset_valid", 32'(pcm_valid), 32'h0);
        chk("reset_overrun", 32'(pcm_overrun), 32'h0);
        chk("reset_dac", 32'(dac_out), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef CENTIPEDE_AUDIO_DCBLOCK_EN
        begin
            logic [15:0] prev;
            int words;
            int nonmono;
            gap = 0;
            volume = 4'd15;
            strobes(31, 8'hFF, 1'b0);
            strobe(8'hFF, 1'b0, 1'b0);
            chk("dc_first_valid", 32'(pcm_valid), 32'h1);
            chk("dc_first_pcm", 32'(pcm_data), 32'h7F00);
            prev = pcm_data;
            strobes(31, 8'hFF, 1'b0);
            strobe(8'hFF, 1'b0, 1'b1);
            chk("dc_second_pcm", 32'(pcm_data), 32'h7E81);
            chk("dc_no_overrun", 32'(pcm_overrun), 32'h0);
            prev = pcm_data;
            words = 2;
            nonmono = 0;
            while (pcm_data >= 16'h0100 && words < 1500) begin
                strobes(31, 8'hFF, 1'b0);
                strobe(8'hFF, 1'b0, 1'b1);
                words++;
                if (pcm_data[15] || pcm_data >= prev) nonmono++;
                prev = pcm_data;
            end
            chk("dc_monotonic", 32'(nonmono), 32'h0);
            chk("dc_below_0100", 32'(pcm_data < 16'h0100), 32'h1);
        end
`else
        vecs[0] = '{8'hFF, 4'd15, 1'b0, 16'h7F00};
        vecs[1] = '{8'h00, 4'd0,  1'b0, 16'hF800};
        vecs[2] = '{8'h80, 4'd7,  1'b0, 16'h0000};
        vecs[3] = '{8'h00, 4'd15, 1'b0, 16'h8000};
        vecs[4] = '{8'hFF, 4'd0,  1'b0, 16'h07F0};
        vecs[5] = '{8'h40, 4'd3,  1'b0, 16'hF000};
        vecs[6] = '{8'hFF, 4'd15, 1'b1, 16'h0000};
        vecs[7] = '{8'h81, 4'd1,  1'b0, 16'h0020};

        for (int v = 0; v < 8; v++) begin
            volume = vecs[v].vol;
            strobes(31, vecs[v].a, 1'b0);
            chk($sformatf("v%0d_pre_valid", v), 32'(pcm_valid), 32'h0);
            strobe(vecs[v].a, vecs[v].m, 1'b0);
            chk($sformatf("v%0d_valid", v), 32'(pcm_valid), 32'h1);
            chk($sformatf("v%0d_pcm", v), 32'(pcm_data), 32'(vecs[v].exp_pcm));
            accept();
            chk($sformatf("v%0d_acc_valid", v), 32'(pcm_valid), 32'h0);
            chk($sformatf("v%0d_acc_hold", v), 32'(pcm_data), 32'(vecs[v].exp_pcm));
        end

        // Mute outside the boundary strobe has no effect.
        volume = 4'd15;
        strobes(31, 8'hFF, 1'b1);
        strobe(8'hFF, 1'b0, 1'b0);
        chk("mute_midframe_pcm", 32'(pcm_data), 32'h7F00);

        // Density of ones for 16'h7F00 is 255/256.
        repeat (2) @(posedge clk);
        #1;
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            ones += int'(dac_out);
        end
        chk("dac_density_7f00", 32'(ones), 32'd255);

        // Boundary coinciding with an accept: valid stays, no overrun.
        volume = 4'd0;
        strobes(31, 8'h00, 1'b0);
        strobe(8'h00, 1'b0, 1'b1);
        chk("coinc_valid", 32'(pcm_valid), 32'h1);
        chk("coinc_pcm", 32'(pcm_data), 32'hF800);
        chk("coinc_overrun", 32'(pcm_overrun), 32'h0);

        // Silence word: dac alternates.
        volume = 4'd9;
        strobes(31, 8'h80, 1'b0);
        strobe(8'h80, 1'b0, 1'b1);
        chk("silence_pcm", 32'(pcm_data), 32'h0);
        accept();
        @(posedge clk);
        #1;
        last = dac_out;
        toggles = 0;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (dac_out != last) toggles++;
            ones += int'(dac_out);
            last = dac_out;
        end
        chk("silence_toggles", 32'(toggles), 32'd16);
        chk("silence_ones", 32'(ones), 32'd8);

        // Two boundaries without ready.
        volume = 4'd15;
        strobes(32, 8'hFF, 1'b0);
        chk("ovr_first_overrun", 32'(pcm_overrun), 32'h0);
        strobes(32, 8'h00, 1'b0);
        chk("ovr_overrun", 32'(pcm_overrun), 32'h1);
        chk("ovr_pcm", 32'(pcm_data), 32'h8000);
        chk("ovr_valid", 32'(pcm_valid), 32'h1);
        accept();
        chk("ovr_acc_valid", 32'(pcm_valid), 32'h0);
        chk("ovr_sticky", 32'(pcm_overrun), 32'h1);
        repeat (5) @(posedge clk);
        #1;
        chk("ovr_valid_stays_low", 32'(pcm_valid), 32'h0);

        // Reset mid-frame with a strobe pending.
        strobes(10, 8'h00, 1'b0);
        #1;
        sample_en = 1'b1;
        audio_in  = 8'h00;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pcm", 32'(pcm_data), 32'h0);
        chk("mid_rst_valid", 32'(pcm_valid), 32'h0);
        chk("mid_rst_overrun", 32'(pcm_overrun), 32'h0);
        chk("mid_rst_dac", 32'(dac_out), 32'h0);
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        rst_n = 1'b1;
        strobes(31, 8'hFF, 1'b0);
        chk("post_rst_31_valid", 32'(pcm_valid), 32'h0);
        strobe(8'hFF, 1'b0, 1'b0);
        chk("post_rst_32_valid", 32'(pcm_valid), 32'h1);
        chk("post_rst_pcm", 32'(pcm_data), 32'h7F00);
        held = pcm_data;
        do_reset();
        chk("final_rst_pcm", 32'(pcm_data), 32'h0);
        chk("final_rst_changed", 32'(pcm_data != held), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
